// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered display image.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int DEAD     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        pending,
  output logic        frame_tick
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] DEAD_C = PW'(DEAD);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic       slot_end, wrap, blank;
  logic [3:0] nib;

  always_comb begin
    pcnt_d      = pcnt_q;
    dig_d       = dig_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;

    slot_end = en && (pcnt_q == P_LAST);
    wrap     = slot_end && (dig_q == 2'd3);

    if (!en) begin
      pcnt_d = '0;
      dig_d  = 2'd0;
    end else if (slot_end) begin
      pcnt_d = '0;
      dig_d  = dig_q + 2'd1;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end

    // A load coinciding with the frame wrap bypasses the shadow entirely;
    // while the scan is idle, pending data commits one cycle after capture.
    if (load) begin
      shadow_d    = data;
      shadow_dp_d = dp_in;
      if (wrap) begin
        disp_d    = data;
        disp_dp_d = dp_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if ((wrap || !en) && pending_q) begin
      disp_d    = shadow_q;
      disp_dp_d = shadow_dp_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    unique case (dig_q)
      2'd0: nib = disp_q[3:0];
      2'd1: nib = disp_q[7:4];
      2'd2: nib = disp_q[11:8];
      2'd3: nib = disp_q[15:12];
      default: nib = 4'h0;
    endcase
`ifdef SSEG_LZB_EN
    unique case (dig_q)
      2'd1: blank = (disp_q[15:4] == 12'h000);
      2'd2: blank = (disp_q[15:8] == 8'h00);
      2'd3: blank = (disp_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif

    seg_d = 7'h7F;
    if (!blank) begin
      unique case (nib)
        4'h0: seg_d = 7'b1000000;
        4'h1: seg_d = 7'b1111001;
        4'h2: seg_d = 7'b0100100;
        4'h3: seg_d = 7'b0110000;
        4'h4: seg_d = 7'b0011001;
        4'h5: seg_d = 7'b0010010;
        4'h6: seg_d = 7'b0000010;
        4'h7: seg_d = 7'b1111000;
        4'h8: seg_d = 7'b0000000;
        4'h9: seg_d = 7'b0010000;
        4'hA: seg_d = 7'b0001000;
        4'hB: seg_d = 7'b0000011;
        4'hC: seg_d = 7'b1000110;
        4'hD: seg_d = 7'b0100001;
        4'hE: seg_d = 7'b0000110;
        4'hF: seg_d = 7'b0001110;
        default: seg_d = 7'h7F;
      endcase
    end

    // Dead time at the start of each slot keeps the previous digit from ghosting.
    if (!en || (pcnt_q < DEAD_C)) an_d = 4'hF;
    else                          an_d = ~(4'b0001 << dig_q);

    dp_d         = ~disp_dp_q[dig_q];
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q       <= '0;
      dig_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      disp_q       <= 16'h0000;
      disp_dp_q    <= 4'h0;
      pending_q    <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (PRESCALE=8, DEAD=2); honours SSEG_LZB_EN.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.PRESCALE(8), .DEAD(2)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .data(data),
    .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .pending(pending),
    .frame_tick(frame_tick)
  );

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int k);
    logic [15:0] hi;
    hi = d >> (4 * k);
`ifdef SSEG_LZB_EN
    if (k != 0 && hi == 16'h0000) return 7'h7F;
`endif
    return hexseg(hi[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full 32-cycle frame starting at slot 0, pcnt 0; optional load before step load_at.
  task automatic run_frame(input logic [15:0] exp_data, input logic [3:0] exp_dp,
                           input int load_at, input logic [15:0] ld_data,
                           input logic [3:0] ld_dp);
    logic       pend;
    logic [3:0] an_exp;
    logic [3:0] one_hot;
    int         dg;
    pend = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == load_at) begin
        load  = 1'b1;
        data  = ld_data;
        dp_in = ld_dp;
      end
      step();
      load = 1'b0;
      if (i == load_at && i != 31) pend = 1'b1;
      if (i == 31) pend = 1'b0;
      dg      = i / 8;
      one_hot = 4'b0001 << dg;
      an_exp  = ((i % 8) < 2) ? 4'hF : ~one_hot;
      chk("an", {12'h0, an}, {12'h0, an_exp});
      chk("seg", {9'h0, seg}, {9'h0, exp_seg(exp_data, dg)});
      chk("dp", {15'h0, dp}, {15'h0, ~exp_dp[dg]});
      chk("frame_tick", {15'h0, frame_tick}, {15'h0, (i == 31)});
      chk("pending", {15'h0, pending}, {15'h0, pend});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    data    = 16'h0000;
    dp_in   = 4'h0;
    step();
    step();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_pending", {15'h0, pending}, 16'h0000);
    chk("rst_frame_tick", {15'h0, frame_tick}, 16'h0000);

    reset_n = 1'b1;
    step();
    chk("idle_an", {12'h0, an}, 16'h000F);

    // Load while idle: pending pulses for exactly one cycle.
    load  = 1'b1;
    data  = 16'h1234;
    dp_in = 4'b0001;
    step();
    load = 1'b0;
    chk("idle_pending_set", {15'h0, pending}, 16'h0001);
    chk("idle_an_dark", {12'h0, an}, 16'h000F);
    step();
    chk("idle_pending_clr", {15'h0, pending}, 16'h0000);
    chk("idle_frame_tick", {15'h0, frame_tick}, 16'h0000);

    en = 1'b1;
    run_frame(16'h1234, 4'b0001, -1, 16'h0000, 4'h0);
    run_frame(16'h1234, 4'b0001, 8, 16'hABCD, 4'b0000);
    run_frame(16'hABCD, 4'b0000, 31, 16'h5555, 4'b1111);
    run_frame(16'h5555, 4'b1111, 31, 16'h0007, 4'b0000);
    run_frame(16'h0007, 4'b0000, -1, 16'h0000, 4'h0);

    // Reset in the digit 2 slot with a load still pending.
    for (int i = 0; i < 17; i++) step();
    load  = 1'b1;
    data  = 16'h9999;
    dp_in = 4'b1010;
    step();
    load = 1'b0;
    chk("mid_pending", {15'h0, pending}, 16'h0001);
    step();
    step();
    reset_n = 1'b0;
    en      = 1'b0;
    step();
    chk("midrst_an", {12'h0, an}, 16'h000F);
    chk("midrst_pending", {15'h0, pending}, 16'h0000);
    chk("midrst_seg", {9'h0, seg}, 16'h007F);
    chk("midrst_dp", {15'h0, dp}, 16'h0001);
    chk("midrst_frame_tick", {15'h0, frame_tick}, 16'h0000);
    step();
    reset_n = 1'b1;
    en      = 1'b1;
    run_frame(16'h0000, 4'b0000, -1, 16'h0000, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
